enemy_array_datapath: RTL and testbench
=======================================

ENEMY_ARRAY_DATAPATH -- requirements
Module: enemy_array_datapath

Interface
REQ-001 SHALL have parameter NUM_ENEMIES, default 4, meaning number of independent enemy slots (1..16).
REQ-002 SHALL have parameter SCREEN_H, default 120, meaning playfield height in pixels.
REQ-003 SHALL have parameter ENEMY_H, default 9, meaning enemy sprite height in pixels.
REQ-004 SHALL have parameter MAX_SPEED, default 8, meaning saturation limit of effective speed in pixels per tick.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 SHALL have port spawnReq, input, 1, request to place a new enemy.
REQ-008 SHALL have ports spawnX (input, 8), spawnSpeed (input, 4) and spawnColour (input, 3), the new enemy's column, base speed and colour.
REQ-009 SHALL have port spawnAck, output, 1, one-cycle pulse confirming a spawn.
REQ-010 SHALL have port full, output, 1, high when no slot is idle.
REQ-011 SHALL have port tick, input, 1, position-update strobe.
REQ-012 SHALL have port score, input, 8, current score for speed tiering.
REQ-013 SHALL have ports hitValid (input, 1) and hitIndex (input, 4), kill request for one slot.
REQ-014 SHALL have output ports enemyX (8*NUM_ENEMIES), enemyY (7*NUM_ENEMIES) and colourOut (3*NUM_ENEMIES), packed per slot, slot i in bits [i*W +: W].
REQ-015 SHALL have output ports active (NUM_ENEMIES), per-slot occupied flag, and bottomReached (NUM_ENEMIES), per-slot one-cycle pulse.
REQ-016 SHALL have port missCount, output, 8, number of enemies that reached the bottom.

Function
REQ-017 Spawn: when spawnReq=1 and an idle slot exists, SHALL load the lowest-index idle slot: X=spawnX, Y=0, base speed, colour, active=1; spawnAck=1 on the next cycle.
REQ-018 Spawn with all slots busy SHALL be dropped: no state change, spawnAck=0.
REQ-019 full SHALL be registered, equal to AND of the active bits after each edge.
REQ-020 Tier bonus: score>=100 -> 4, >=50 -> 3, >=30 -> 2, >=10 -> 1, else 0; for base speed >=3 the bonus SHALL be ceil(bonus/2).
REQ-021 Effective speed = base + bonus, computed combinationally from the current score at each tick, saturated at MAX_SPEED.
REQ-022 On tick, each active slot SHALL compute next = Y + effective speed at width >= 9 bits (no wrap).
REQ-023 If next + ENEMY_H >= SCREEN_H the slot SHALL go idle, Y=0, bottomReached[i] pulses for one cycle, and missCount increments.
REQ-024 Otherwise, on tick, Y SHALL be set to next.
REQ-025 missCount SHALL saturate at 255 and SHALL add the number of slots reaching bottom in the same tick.
REQ-026 hitValid with hitIndex < NUM_ENEMIES and that slot active SHALL make the slot idle with Y=0 and no bottomReached pulse.
REQ-027 hitValid naming an idle or out-of-range slot SHALL be ignored.
REQ-028 Hit and tick on the same slot in the same cycle: hit SHALL win (no move, no pulse, no miss).
REQ-029 A slot freed this cycle SHALL NOT be spawn-eligible until the next cycle.
REQ-030 A slot spawned in a tick cycle SHALL NOT move that cycle.
REQ-031 colourOut of an idle slot SHALL read 3'b000; enemyX SHALL hold its last value.

Reset
REQ-032 When resetn=0 at a clock edge, every slot SHALL go idle with X=0, Y=0, colour=0, and spawnAck, full, bottomReached and missCount SHALL become 0.
REQ-033 Reset SHALL override simultaneous spawn, tick and hit, including mid-flight enemies.

Verification
REQ-034 Reset, then spawnReq X=40, speed=2, colour=3'b101, score=0 -> slot0 active, Y=0, spawnAck pulse; 5 ticks -> Y=10.
REQ-035 score=50, base 1 -> 4 px/tick; base 5 -> 7 px/tick; base 7 with score=100 -> 8 (saturated).
REQ-036 Slot at Y=108, speed 3, tick -> 111+9>=120: slot idle, bottomReached[0] pulse, missCount=1.
REQ-037 Fill 4 slots, spawn again -> spawnAck=0, full=1; hit slot 2 with spawn in the same cycle -> dropped; spawn next cycle -> slot 2 used.
REQ-038 Hit and tick on slot 1 at Y=110 in the same cycle -> slot idle, no bottomReached, missCount unchanged.
REQ-039 resetn low during active ticks -> all outputs zero the following cycle.

Source files
------------

// File: rtl/enemy_array_datapath.sv
// enemy_array_datapath: fixed pool of falling enemy slots with spawn, tick-driven descent, hits and miss counting
// Ports: clk/resetn (sync active-low); spawnReq/spawnX/spawnSpeed/spawnColour -> spawnAck, full;
//        tick/score drive descent; hitValid/hitIndex kill a slot; per-slot enemyX/enemyY/colourOut/active/
//        bottomReached packed as slot i at [i*W +: W]; missCount counts enemies that reached the bottom.
module enemy_array_datapath #(
    parameter int NUM_ENEMIES = 4,
    parameter int SCREEN_H = 120,
    parameter int ENEMY_H = 9,
    parameter int MAX_SPEED = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     spawnReq,
    input  logic [7:0]               spawnX,
    input  logic [3:0]               spawnSpeed,
    input  logic [2:0]               spawnColour,
    output logic                     spawnAck,
    output logic                     full,
    input  logic                     tick,
    input  logic [7:0]               score,
    input  logic                     hitValid,
    input  logic [3:0]               hitIndex,
    output logic [8*NUM_ENEMIES-1:0] enemyX,
    output logic [7*NUM_ENEMIES-1:0] enemyY,
    output logic [3*NUM_ENEMIES-1:0] colourOut,
    output logic [NUM_ENEMIES-1:0]   active,
    output logic [NUM_ENEMIES-1:0]   bottomReached,
    output logic [7:0]               missCount
);
    logic [7:0]             r_x   [NUM_ENEMIES];
    logic [6:0]             r_y   [NUM_ENEMIES];
    logic [3:0]             r_spd [NUM_ENEMIES];
    logic [2:0]             r_col [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] r_act;
    logic [2:0]             w_tier;
    logic [2:0]             w_bonus;
    logic [4:0]             w_sum;
    logic [4:0]             w_eff  [NUM_ENEMIES];
    logic [9:0]             w_next [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] w_hit;
    logic [NUM_ENEMIES-1:0] w_bot;
    logic [NUM_ENEMIES-1:0] w_act_n;
    logic [3:0]             w_sel;
    logic                   w_spawn;
    logic [4:0]             w_miss_add;
    logic [8:0]             w_miss_sum;

    assign w_tier = score >= 8'd100 ? 3'd4 : score >= 8'd50 ? 3'd3 :
                    score >= 8'd30 ? 3'd2 : score >= 8'd10 ? 3'd1 : 3'd0;

    // Spawn eligibility uses the registered active bits, so a slot freed this cycle waits a cycle.
    always_comb begin
        w_sel = '0;
        w_bonus = '0;
        w_sum = '0;
        w_hit = '0;
        w_bot = '0;
        w_miss_add = '0;
        w_act_n = r_act;
        w_spawn = spawnReq && !(&r_act);
        for (int i = NUM_ENEMIES - 1; i >= 0; i--)
            if (!r_act[i]) w_sel = 4'(i);
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            w_hit[i] = hitValid && hitIndex == 4'(i) && r_act[i];
            // Fast base speeds only get half the tier bonus, rounded up.
            w_bonus = r_spd[i] >= 4'd3 ? (w_tier + 3'd1) >> 1 : w_tier;
            w_sum = 5'(r_spd[i]) + 5'(w_bonus);
            w_eff[i] = w_sum > 5'(MAX_SPEED) ? 5'(MAX_SPEED) : w_sum;
            w_next[i] = 10'(r_y[i]) + 10'(w_eff[i]);
            w_bot[i] = tick && r_act[i] && !w_hit[i] && (w_next[i] + 10'(ENEMY_H) >= 10'(SCREEN_H));
            w_miss_add = w_miss_add + 5'(w_bot[i]);
            if (w_hit[i] || w_bot[i]) w_act_n[i] = 1'b0;
            if (w_spawn && w_sel == 4'(i)) w_act_n[i] = 1'b1;
        end
        w_miss_sum = 9'(missCount) + 9'(w_miss_add);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_act <= '0;
            spawnAck <= 1'b0;
            full <= 1'b0;
            bottomReached <= '0;
            missCount <= '0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
                r_spd[i] <= '0;
                r_col[i] <= '0;
            end
        end else begin
            r_act <= w_act_n;
            spawnAck <= w_spawn;
            full <= &w_act_n;
            bottomReached <= w_bot;
            missCount <= w_miss_sum > 9'd255 ? 8'd255 : w_miss_sum[7:0];
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                if (w_spawn && w_sel == 4'(i)) begin
                    r_x[i] <= spawnX;
                    r_y[i] <= '0;
                    r_spd[i] <= spawnSpeed;
                    r_col[i] <= spawnColour;
                end else if (w_hit[i] || w_bot[i]) begin
                    r_y[i] <= '0;
                end else if (tick && r_act[i]) begin
                    r_y[i] <= w_next[i][6:0];
                end
            end
        end
    end

    assign active = r_act;
    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_out
        assign enemyX[g*8 +: 8] = r_x[g];
        assign enemyY[g*7 +: 7] = r_y[g];
        assign colourOut[g*3 +: 3] = r_act[g] ? r_col[g] : 3'b000;
    end
endmodule

// File: tb/tb_enemy_array_datapath.sv
// tb_enemy_array_datapath: directed scenarios plus randomized traffic against a slot-level reference model
module tb_enemy_array_datapath;
    localparam int N = 4;
    localparam int SH = 120;
    localparam int EH = 9;
    localparam int MS = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic spawnReq = 1'b0;
    logic [7:0] spawnX = '0;
    logic [3:0] spawnSpeed = '0;
    logic [2:0] spawnColour = '0;
    logic tick = 1'b0;
    logic [7:0] score = '0;
    logic hitValid = 1'b0;
    logic [3:0] hitIndex = '0;
    logic spawnAck, full;
    logic [8*N-1:0] enemyX;
    logic [7*N-1:0] enemyY;
    logic [3*N-1:0] colourOut;
    logic [N-1:0] active, bottomReached;
    logic [7:0] missCount;

    int total = 0;
    int bad = 0;

    int m_act[N], m_x[N], m_y[N], m_spd[N], m_col[N], m_bot[N];
    int m_ack, m_full, m_miss;

    enemy_array_datapath dut (
        .clk(clk), .resetn(resetn), .spawnReq(spawnReq), .spawnX(spawnX),
        .spawnSpeed(spawnSpeed), .spawnColour(spawnColour), .spawnAck(spawnAck),
        .full(full), .tick(tick), .score(score), .hitValid(hitValid), .hitIndex(hitIndex),
        .enemyX(enemyX), .enemyY(enemyY), .colourOut(colourOut), .active(active),
        .bottomReached(bottomReached), .missCount(missCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int speed_of(input int base, input int sc);
        int b;
        b = sc >= 100 ? 4 : sc >= 50 ? 3 : sc >= 30 ? 2 : sc >= 10 ? 1 : 0;
        if (base >= 3) b = (b + 1) / 2;
        return (base + b > MS) ? MS : base + b;
    endfunction

    task automatic model_step();
        int sel, nb, ny;
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_spd[i] = 0; m_col[i] = 0; m_bot[i] = 0;
            end
            m_ack = 0; m_full = 0; m_miss = 0;
            return;
        end
        sel = -1;
        nb = 0;
        for (int i = 0; i < N; i++) if (sel < 0 && m_act[i] == 0) sel = i;
        m_ack = (spawnReq && sel >= 0) ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            m_bot[i] = 0;
            if (m_act[i] != 0) begin
                if (hitValid && int'(hitIndex) == i) begin
                    m_act[i] = 0; m_y[i] = 0;
                end else if (tick) begin
                    ny = m_y[i] + speed_of(m_spd[i], int'(score));
                    if (ny + EH >= SH) begin
                        m_act[i] = 0; m_y[i] = 0; m_bot[i] = 1; nb++;
                    end else m_y[i] = ny;
                end
            end
        end
        if (m_ack != 0) begin
            m_act[sel] = 1; m_x[sel] = int'(spawnX); m_y[sel] = 0;
            m_spd[sel] = int'(spawnSpeed); m_col[sel] = int'(spawnColour);
        end
        m_miss = (m_miss + nb > 255) ? 255 : m_miss + nb;
        m_full = 1;
        for (int i = 0; i < N; i++) if (m_act[i] == 0) m_full = 0;
    endtask

    task automatic compare_all();
        logic [8*N-1:0] ex;
        logic [7*N-1:0] ey;
        logic [3*N-1:0] ec;
        logic [N-1:0] ea, eb;
        for (int i = 0; i < N; i++) begin
            ex[i*8 +: 8] = 8'(m_x[i]);
            ey[i*7 +: 7] = 7'(m_y[i]);
            ec[i*3 +: 3] = m_act[i] != 0 ? 3'(m_col[i]) : 3'b000;
            ea[i] = m_act[i] != 0;
            eb[i] = m_bot[i] != 0;
        end
        chk("spawnAck", 64'(spawnAck), 64'(m_ack));
        chk("full", 64'(full), 64'(m_full));
        chk("missCount", 64'(missCount), 64'(m_miss));
        chk("active", 64'(active), 64'(ea));
        chk("bottomReached", 64'(bottomReached), 64'(eb));
        chk("enemyX", 64'(enemyX), 64'(ex));
        chk("enemyY", 64'(enemyY), 64'(ey));
        chk("colourOut", 64'(colourOut), 64'(ec));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        spawnReq = 1'b0; tick = 1'b0; hitValid = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic spawn(input logic [7:0] x, input logic [3:0] s, input logic [2:0] c);
        spawnReq = 1'b1; spawnX = x; spawnSpeed = s; spawnColour = c;
        step();
        spawnReq = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_active", 64'(active), 64'd0);
        chk("reset_miss", 64'(missCount), 64'd0);

        score = 8'd0;
        spawn(8'd40, 4'd2, 3'b101);
        chk("spawn_ack", 64'(spawnAck), 64'd1);
        chk("spawn_active", 64'(active), 64'b0001);
        chk("spawn_x", 64'(enemyX[7:0]), 64'd40);
        chk("spawn_col", 64'(colourOut[2:0]), 64'b101);
        step();
        chk("ack_one_cycle", 64'(spawnAck), 64'd0);
        ticks(5);
        chk("y_after_5", 64'(enemyY[6:0]), 64'd10);

        do_reset();
        score = 8'd50;
        spawn(8'd1, 4'd1, 3'd1);
        ticks(1);
        chk("speed_b1_s50", 64'(enemyY[6:0]), 64'd4);
        do_reset();
        spawn(8'd1, 4'd5, 3'd1);
        ticks(1);
        chk("speed_b5_s50", 64'(enemyY[6:0]), 64'd7);
        do_reset();
        score = 8'd100;
        spawn(8'd1, 4'd7, 3'd1);
        ticks(1);
        chk("speed_sat", 64'(enemyY[6:0]), 64'd8);

        do_reset();
        score = 8'd0;
        spawn(8'd5, 4'd3, 3'd2);
        ticks(36);
        chk("y_108", 64'(enemyY[6:0]), 64'd108);
        ticks(1);
        chk("bottom_pulse", 64'(bottomReached), 64'b0001);
        chk("bottom_idle", 64'(active), 64'd0);
        chk("bottom_miss", 64'(missCount), 64'd1);
        step();
        chk("bottom_one_cycle", 64'(bottomReached), 64'd0);

        spawn(8'd9, 4'd4, 3'd6);
        spawn(8'd8, 4'd2, 3'd7);
        ticks(3);
        resetn = 1'b0; spawnReq = 1'b1; tick = 1'b1; hitValid = 1'b1; hitIndex = 4'd0;
        step();
        resetn = 1'b1; spawnReq = 1'b0; tick = 1'b0; hitValid = 1'b0;
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_y", 64'(enemyY), 64'd0);
        chk("rst_x", 64'(enemyX), 64'd0);
        chk("rst_miss", 64'(missCount), 64'd0);

        spawn(8'd10, 4'd1, 3'd1);
        spawn(8'd20, 4'd1, 3'd2);
        spawn(8'd30, 4'd1, 3'd3);
        spawn(8'd40, 4'd1, 3'd4);
        chk("fill_full", 64'(full), 64'd1);
        spawn(8'd50, 4'd1, 3'd5);
        chk("drop_ack", 64'(spawnAck), 64'd0);
        hitValid = 1'b1; hitIndex = 4'd2;
        spawn(8'd99, 4'd1, 3'd5);
        hitValid = 1'b0;
        chk("hit_spawn_ack", 64'(spawnAck), 64'd0);
        chk("hit_spawn_active", 64'(active), 64'b1011);
        spawn(8'd77, 4'd1, 3'd6);
        chk("reuse_ack", 64'(spawnAck), 64'd1);
        chk("reuse_x", 64'(enemyX[23:16]), 64'd77);

        do_reset();
        score = 8'd0;
        spawn(8'd1, 4'd0, 3'd1);
        spawn(8'd2, 4'd2, 3'd2);
        ticks(55);
        chk("y_110", 64'(enemyY[13:7]), 64'd110);
        tick = 1'b1; hitValid = 1'b1; hitIndex = 4'd1;
        step();
        tick = 1'b0; hitValid = 1'b0;
        chk("hit_wins_bot", 64'(bottomReached), 64'd0);
        chk("hit_wins_miss", 64'(missCount), 64'd0);
        chk("hit_wins_active", 64'(active), 64'b0001);

        for (int k = 0; k < 3000; k++) begin
            resetn = $urandom_range(63) != 0;
            spawnReq = 1'($urandom_range(1));
            spawnX = 8'($urandom);
            spawnSpeed = 4'($urandom);
            spawnColour = 3'($urandom);
            tick = 1'($urandom_range(1));
            score = 8'($urandom_range(120));
            hitValid = $urandom_range(2) == 0;
            hitIndex = 4'($urandom_range(5));
            step();
        end

        resetn = 1'b1;
        hitValid = 1'b0;
        score = 8'd100;
        for (int k = 0; k < 1500; k++) begin
            spawnReq = 1'b1;
            spawnX = 8'($urandom);
            spawnSpeed = 4'($urandom_range(15, 8));
            spawnColour = 3'($urandom);
            tick = 1'b1;
            step();
        end
        chk("miss_saturated", 64'(missCount), 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
